// File: rtl/alu.sv
// 32-bit MIPS ALU with combinational Result/Zero/Overflow and a clocked status register.
// Define ALU_EXT_OPS_EN to decode the extended XOR/SLL/SRL/SRA/SLTU operations.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUC,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] Result_r,
  output logic             Zero_r,
  output logic             Overflow_r
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_EXT_OPS_EN
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam int         SHW     = $clog2(WIDTH);
`endif

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] result_s;
  logic             overflow_s;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  assign sum_s  = A + B;
  assign diff_s = A - B;

  // Operation decode; overflow only ever reported for ADD and SUB.
  always_comb begin
    result_s   = {WIDTH{1'b0}};
    overflow_s = 1'b0;
    case (ALUC)
      OP_AND: result_s = A & B;
      OP_OR:  result_s = A | B;
      OP_ADD: begin
        result_s   = sum_s;
        overflow_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result_s   = diff_s;
        overflow_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: result_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: result_s = ~(A | B);
`ifdef ALU_EXT_OPS_EN
      OP_XOR:  result_s = A ^ B;
      OP_SLL:  result_s = B << A[SHW-1:0];
      OP_SRL:  result_s = B >> A[SHW-1:0];
      OP_SRA:  result_s = $unsigned($signed(B) >>> A[SHW-1:0]);
      OP_SLTU: result_s = {{(WIDTH-1){1'b0}}, (A < B)};
`endif
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  assign Result   = result_s;
  assign Zero     = (result_s == {WIDTH{1'b0}});
  assign Overflow = overflow_s;

  assign result_d   = result_s;
  assign zero_d     = Zero;
  assign overflow_d = overflow_s;

  // Status register: one-cycle snapshot of the combinational outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= {WIDTH{1'b0}};
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign Result_r   = result_q;
  assign Zero_r     = zero_q;
  assign Overflow_r = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour and randomized
// operations checked against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUC;
  logic [31:0] Result;
  logic        Zero;
  logic        Overflow;
  logic [31:0] Result_r;
  logic        Zero_r;
  logic        Overflow_r;

  int n_cmp = 0;
  int n_err = 0;

  localparam longint MOD  = 64'sh1_0000_0000;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUC(ALUC),
    .Result(Result), .Zero(Zero), .Overflow(Overflow),
    .Result_r(Result_r), .Zero_r(Zero_r), .Overflow_r(Overflow_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic on 64-bit values.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic v);
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint sh = longint'({59'd0, a[4:0]});
    longint s;
    r = 32'd0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        r = 32'((ua + ub) % MOD);
        s = sa + sb;
        v = (s > MAXS) || (s < MINS);
      end
      4'b0110: begin
        r = 32'((ua - ub + MOD) % MOD);
        s = sa - sb;
        v = (s > MAXS) || (s < MINS);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
`ifdef ALU_EXT_OPS_EN
      4'b0011: r = a ^ b;
      4'b1000: r = 32'((ub * (64'sd1 <<< sh)) % MOD);
      4'b1001: r = 32'(ub / (64'sd1 <<< sh));
      4'b1010: r = 32'(sb >>> sh);
      4'b1011: r = (ua < ub) ? 32'd1 : 32'd0;
`endif
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'd0;
      1: pick = 32'h7FFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = 32'hFFFF_FFFF;
      4: pick = 32'($urandom_range(0, 40));
      default: pick = $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    A = 32'd0; B = 32'd0; ALUC = 4'b0000;
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (Result_r !== 32'd0 || Zero_r !== 1'b0 || Overflow_r !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial: got R=%h Z=%b V=%b want 0/0/0", Result_r, Zero_r, Overflow_r);
    end
    A = 32'd3; B = 32'd4; ALUC = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (Result_r !== 32'd0 || Zero_r !== 1'b0 || Overflow_r !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: got R=%h Z=%b V=%b want 0/0/0", Result_r, Zero_r, Overflow_r);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    tbl.push_back('{4'b0010, 32'd15, 32'd10, 32'd25, 1'b0, 1'b0});
    tbl.push_back('{4'b0110, 32'd10, 32'd15, 32'hFFFF_FFFB, 1'b0, 1'b0});
    tbl.push_back('{4'b0110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0000, 32'd12, 32'd5, 32'd4, 1'b0, 1'b0});
    tbl.push_back('{4'b0001, 32'd12, 32'd5, 32'd13, 1'b0, 1'b0});
    tbl.push_back('{4'b1100, 32'd12, 32'd5, 32'hFFFF_FFF2, 1'b0, 1'b0});
    tbl.push_back('{4'b0111, 32'd5, 32'd12, 32'd1, 1'b0, 1'b0});
    tbl.push_back('{4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0});
    tbl.push_back('{4'b0111, 32'd12, 32'd5, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1});
    tbl.push_back('{4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{4'b1111, 32'd9, 32'd3, 32'd0, 1'b1, 1'b0});
`ifdef ALU_EXT_OPS_EN
    tbl.push_back('{4'b1000, 32'd4, 32'd1, 32'd16, 1'b0, 1'b0});
    tbl.push_back('{4'b1010, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0});
    tbl.push_back('{4'b0011, 32'd12, 32'd5, 32'd9, 1'b0, 1'b0});
`else
    tbl.push_back('{4'b1000, 32'd4, 32'd1, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b1010, 32'd4, 32'h8000_0000, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{4'b0011, 32'd12, 32'd5, 32'd0, 1'b1, 1'b0});
`endif
    foreach (tbl[i]) begin
      @(negedge clk);
      A = tbl[i].a; B = tbl[i].b; ALUC = tbl[i].op;
      #1;
      n_cmp++;
      if (Result !== tbl[i].r || Zero !== tbl[i].z || Overflow !== tbl[i].v) begin
        n_err++;
        $display("FAIL directed[%0d] op=%b: got R=%h Z=%b V=%b want R=%h Z=%b V=%b",
                 i, tbl[i].op, Result, Zero, Overflow, tbl[i].r, tbl[i].z, tbl[i].v);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (Result_r !== tbl[i].r || Zero_r !== tbl[i].z || Overflow_r !== tbl[i].v) begin
        n_err++;
        $display("FAIL directed_reg[%0d]: got R=%h Z=%b V=%b want R=%h Z=%b V=%b",
                 i, Result_r, Zero_r, Overflow_r, tbl[i].r, tbl[i].z, tbl[i].v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] ra[2] = '{32'd15, 32'h7FFF_FFFF};
    logic [31:0] rb[2] = '{32'd10, 32'd1};
    logic [31:0] er[2] = '{32'd25, 32'h8000_0000};
    logic        ev[2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      A = ra[k]; B = rb[k]; ALUC = 4'b0010;
      @(posedge clk);
      #1;
      n_cmp++;
      if (Result_r !== er[k] || Overflow_r !== ev[k]) begin
        n_err++;
        $display("FAIL rst_load[%0d]: got R=%h V=%b want R=%h V=%b", k, Result_r, Overflow_r, er[k], ev[k]);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (Result_r !== 32'd0 || Zero_r !== 1'b0 || Overflow_r !== 1'b0) begin
        n_err++;
        $display("FAIL rst_async[%0d]: got R=%h Z=%b V=%b want 0/0/0", k, Result_r, Zero_r, Overflow_r);
      end
      n_cmp++;
      if (Result !== er[k] || Overflow !== ev[k]) begin
        n_err++;
        $display("FAIL rst_comb[%0d]: got R=%h V=%b want R=%h V=%b", k, Result, Overflow, er[k], ev[k]);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (Result_r !== 32'd0 || Overflow_r !== 1'b0) begin
        n_err++;
        $display("FAIL rst_hold[%0d]: got R=%h V=%b want 0/0", k, Result_r, Overflow_r);
      end
      @(negedge clk) reset = 1'b0;
      #1;
      n_cmp++;
      if (Result_r !== 32'd0) begin
        n_err++;
        $display("FAIL rst_release[%0d]: got R=%h want 0", k, Result_r);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (Result_r !== er[k] || Overflow_r !== ev[k]) begin
        n_err++;
        $display("FAIL rst_reload[%0d]: got R=%h V=%b want R=%h V=%b", k, Result_r, Overflow_r, er[k], ev[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] er;
    logic        ez, ev;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      A = pick(); B = pick(); ALUC = 4'($urandom_range(0, 15));
      model(ALUC, A, B, er, ez, ev);
      #1;
      n_cmp++;
      if (Result !== er || Zero !== ez || Overflow !== ev) begin
        n_err++;
        $display("FAIL random[%0d] op=%b A=%h B=%h: got R=%h Z=%b V=%b want R=%h Z=%b V=%b",
                 i, ALUC, A, B, Result, Zero, Overflow, er, ez, ev);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (Result_r !== er || Zero_r !== ez || Overflow_r !== ev) begin
        n_err++;
        $display("FAIL random_reg[%0d]: got R=%h Z=%b V=%b want R=%h Z=%b V=%b",
                 i, Result_r, Zero_r, Overflow_r, er, ez, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the single-cycle MIPS datapath, selected by the 4-bit ALUC code from ALU control.
- Result and Zero are combinational, used same-cycle by the register-file write-back and the branch logic.
- A clocked status register captures Result, Zero and Overflow every cycle for debug and flag use.

Parameters:
- WIDTH, 32, datapath width of A, B and Result. Only 32 is required to work.

Ports:
- clk  input  1  rising-edge clock; clocks the status register only.
- reset  input  1  asynchronous, active-high; clears the status register.
- A  input  32  operand A (rs).
- B  input  32  operand B (rt or immediate).
- ALUC  input  4  operation select.
- Result  output  32  combinational result.
- Zero  output  1  combinational; 1 when Result == 0.
- Overflow  output  1  combinational signed overflow; meaningful for ADD/SUB, 0 for all other ops.
- Result_r  output  32  registered Result.
- Zero_r  output  1  registered Zero.
- Overflow_r  output  1  registered Overflow.

Behaviour:
- Combinational path; no clock involvement, so outputs settle within the same cycle as the inputs.
- ALUC decode:
  - 0000 AND: A & B.
  - 0001 OR: A | B.
  - 0010 ADD: A + B, modulo 2^32.
  - 0110 SUB: A - B, modulo 2^32.
  - 0111 SLT: signed compare; Result = {31'b0, ($signed(A) < $signed(B))}.
  - 1100 NOR: ~(A | B).
  - Extended codes (only with the optional feature): 0011 XOR, 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLTU.
  - Any other code: Result = 0.
- Shifts:
  - Shift B by A[4:0]; A[31:5] are ignored.
  - SRA replicates B[31].
  - SLTU is an unsigned compare of A and B, giving 0 or 1.
- Overflow:
  - ADD: 1 when A[31] == B[31] and Result[31] != A[31].
  - SUB: 1 when A[31] != B[31] and Result[31] != A[31].
  - Overflow never alters Result; no trap is raised.
- Zero is derived from the final Result of every op, including undefined codes (Zero = 1 for those).
- Status register:
  - On each rising clk, Result_r/Zero_r/Overflow_r <= Result/Zero/Overflow.
  - Latency is 1 cycle.
  - reset asserted, at any time and asynchronously: Result_r = 0, Zero_r = 0, Overflow_r = 0.
  - Outputs hold these reset values until the first rising clk after reset deasserts.
- Combinational outputs are unaffected by reset.
- X/Z on the inputs is not handled specially.

Optional Feature:
- Macro: ALU_EXT_OPS_EN.
- Defined: XOR, SLL, SRL, SRA and SLTU are decoded as listed under Behaviour.
- Undefined: codes 0011 and 1000-1011 fall into the default case, giving Result = 0 and Zero = 1; only the six base ops exist.
- Overflow and the status register behave identically in both builds.

Test Plan:
- ADD: A=15, B=10, ALUC=0010 -> Result=25, Zero=0, Overflow=0; after next clk, Result_r=25.
- SUB: A=10, B=15, ALUC=0110 -> Result=32'hFFFFFFFB, Zero=0. Also A=B=7 -> Result=0, Zero=1.
- Logic, A=12, B=5:
  - AND (0000) -> 4.
  - OR (0001) -> 13.
  - NOR (1100) -> 32'hFFFFFFF2.
  - All three give Zero=0.
- SLT:
  - A=5, B=12, ALUC=0111 -> Result=1, Zero=0.
  - A=32'hFFFFFFFF, B=1 -> Result=1.
  - A=12, B=5 -> Result=0, Zero=1.
- Overflow:
  - A=32'h7FFFFFFF, B=1, ADD -> Result=32'h80000000, Overflow=1.
  - A=32'h80000000, B=1, SUB -> Overflow=1.
  - Undefined code 1111 -> Result=0, Zero=1.
- Reset: load Result_r=25, then assert reset between clock edges -> Result_r, Zero_r and Overflow_r go to 0 immediately and hold while reset is high.
- With ALU_EXT_OPS_EN defined: SLL A=4, B=1 -> 16; SRA A=4, B=32'h80000000 -> 32'hF8000000.
